// File: rtl/clock_enable_gen_if.sv
// Divisor programming bus for clock_enable_gen.
// Master writes shadow divisors; slave reports per-channel pending flags.
interface clock_enable_gen_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 26
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_val;
    logic [NCH-1:0]   div_pend;

    modport master (
        output div_wr,
        output div_sel,
        output div_val,
        input  div_pend
    );

    modport slave (
        input  div_wr,
        input  div_sel,
        input  div_val,
        output div_pend
    );
endinterface

// File: rtl/clock_enable_gen.sv
// Runtime-programmable multi-channel clock-enable generator with free counter.
// Define CLKEN_SQUARE_EN to build the per-channel 50% square-wave outputs.
module clock_enable_gen #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 26,
    parameter int FREE_W  = 31,
    parameter int DEF_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    i_ch_en,
    clock_enable_gen_if.slave bus,
    output logic [NCH-1:0]    o_tick,
    output logic [NCH-1:0]    o_sq,
    output logic [FREE_W-1:0] o_free_cnt
);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    logic [NCH-1:0]    w_pend;
    logic [FREE_W-1:0] r_free;

    assign bus.div_pend = w_pend;
    assign o_free_cnt   = r_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free <= '0;
        end else begin
            r_free <= r_free + FREE_W'(1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_act;
        logic [CNT_W-1:0] r_shd;
        logic             r_pend;
        logic             r_tick;
        logic             w_hit;
        logic             w_term;

        // Out-of-range selects never match any channel index.
        assign w_hit  = bus.div_wr && (int'(bus.div_sel) == g);
        assign w_term = (r_cnt == r_act);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_act  <= RST_DIV;
                r_shd  <= RST_DIV;
                r_pend <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                if (i_ch_en[g]) begin
                    if (w_term) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end
                // Swap only on a period boundary, or freely while idle.
                if (r_pend && (!i_ch_en[g] || w_term)) begin
                    r_act  <= r_shd;
                    r_pend <= 1'b0;
                end
                if (w_hit) begin
                    r_shd  <= bus.div_val;
                    r_pend <= 1'b1;
                end
            end
        end

        assign o_tick[g] = r_tick;
        assign w_pend[g] = r_pend;

`ifdef CLKEN_SQUARE_EN
        logic r_sq;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sq <= 1'b0;
            end else if (i_ch_en[g] && w_term) begin
                r_sq <= ~r_sq;
            end
        end

        assign o_sq[g] = r_sq;
`else
        assign o_sq[g] = 1'b0;
`endif
    end
endmodule
